// File: rtl/myproject_mac_pkg.sv
// Shared encodings and width helpers for the pipelined signed MAC unit.
package myproject_mac_pkg;

   localparam logic MAC_MODE_MUL = 1'b0;
   localparam logic MAC_MODE_ACC = 1'b1;

   function automatic int prod_w(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   function automatic int acc_w(input int a_w, input int b_w, input int guard);
      return a_w + b_w + guard;
   endfunction

   function automatic longint sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/myproject_mul_pipe.sv
// Full-precision signed product with a NUM_STAGE register chain and matching sideband delay.
module myproject_mul_pipe import myproject_mac_pkg::*; #(
   parameter int NUM_STAGE = 2,
   parameter int A_W       = 16,
   parameter int B_W       = 17,
   localparam int P_W      = prod_w(A_W, B_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic signed [A_W-1:0] a,
   input  logic signed [B_W-1:0] b,
   input  logic                  in_mode,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  p_valid,
   output logic signed [P_W-1:0] p,
   output logic                  p_mode,
   output logic                  p_first,
   output logic                  p_last
);

   logic signed [P_W-1:0] prod;
   assign prod = P_W'(a) * P_W'(b);

   if (NUM_STAGE == 0) begin : g_comb
      assign p_valid = in_valid;
      assign p       = prod;
      assign p_mode  = in_mode;
      assign p_first = in_first;
      assign p_last  = in_last;
   end else begin : g_reg
      logic [NUM_STAGE-1:0]  v_q, m_q, f_q, l_q;
      logic signed [P_W-1:0] p_q [NUM_STAGE];

      // Only the valid bits need a reset; the payload is qualified by them.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= '0;
         end else if (en) begin
            for (int s = NUM_STAGE - 1; s > 0; s--) v_q[s] <= v_q[s-1];
            v_q[0] <= in_valid;
         end
      end

      always_ff @(posedge clk) begin
         if (en) begin
            for (int s = NUM_STAGE - 1; s > 0; s--) begin
               p_q[s] <= p_q[s-1];
               m_q[s] <= m_q[s-1];
               f_q[s] <= f_q[s-1];
               l_q[s] <= l_q[s-1];
            end
            p_q[0] <= prod;
            m_q[0] <= in_mode;
            f_q[0] <= in_first;
            l_q[0] <= in_last;
         end
      end

      assign p_valid = v_q[NUM_STAGE-1];
      assign p       = p_q[NUM_STAGE-1];
      assign p_mode  = m_q[NUM_STAGE-1];
      assign p_first = f_q[NUM_STAGE-1];
      assign p_last  = l_q[NUM_STAGE-1];
   end

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply / dot-product accumulate with valid-ready flow control
// and a rounding, saturating output requantiser.
module myproject_mac_pipe import myproject_mac_pkg::*; #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 17,
   parameter int ACC_GUARD  = 4,
   parameter int OUT_SHIFT  = 0,
   parameter int dout_WIDTH = 31
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic signed [din1_WIDTH-1:0] din1,
   input  logic                         in_mode,
   input  logic                         in_first,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic                         dout_ovf
);

   localparam int P_W   = prod_w(din0_WIDTH, din1_WIDTH);
   localparam int ACC_W = acc_w(din0_WIDTH, din1_WIDTH, ACC_GUARD);
   // One spare bit absorbs the rounding offset; widen further if dout is wider still.
   localparam int WIDE  = (ACC_W + 1 > dout_WIDTH) ? ACC_W + 1 : dout_WIDTH + 1;
   localparam int HS    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [WIDE-1:0] HALF   = (OUT_SHIFT > 0) ? (WIDE'(1) <<< HS) : '0;
   localparam logic signed [WIDE-1:0] LIM_HI = WIDE'(sat_hi(dout_WIDTH));
   localparam logic signed [WIDE-1:0] LIM_LO = WIDE'(sat_lo(dout_WIDTH));

   logic                  en;
   logic                  p_valid, p_mode, p_first, p_last;
   logic signed [P_W-1:0] p;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   myproject_mul_pipe #(
      .NUM_STAGE (NUM_STAGE),
      .A_W       (din0_WIDTH),
      .B_W       (din1_WIDTH)
   ) u_mul (
      .clk      (ap_clk),
      .rst      (ap_rst),
      .en       (en),
      .in_valid (in_valid),
      .a        (din0),
      .b        (din1),
      .in_mode  (in_mode),
      .in_first (in_first),
      .in_last  (in_last),
      .p_valid  (p_valid),
      .p        (p),
      .p_mode   (p_mode),
      .p_first  (p_first),
      .p_last   (p_last)
   );

   logic signed [ACC_W-1:0]      acc, prod_ext, sum, pick;
   logic signed [WIDE-1:0]       rnd, r;
   logic signed [dout_WIDTH-1:0] q_d;
   logic                         q_ovf, emit;

   always_comb begin
      prod_ext = ACC_W'(p);
      sum      = p_first ? prod_ext : acc + prod_ext;
      pick     = (p_mode == MAC_MODE_ACC) ? sum : prod_ext;
      rnd      = WIDE'(pick) + HALF;
      r        = rnd >>> OUT_SHIFT;
      q_ovf    = 1'b0;
      q_d      = dout_WIDTH'(r);
      if (r > LIM_HI) begin
         q_d   = dout_WIDTH'(LIM_HI);
         q_ovf = 1'b1;
      end else if (r < LIM_LO) begin
         q_d   = dout_WIDTH'(LIM_LO);
         q_ovf = 1'b1;
      end
      emit = p_valid && ((p_mode == MAC_MODE_MUL) || p_last);
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         dout_ovf  <= 1'b0;
         acc       <= '0;
      end else if (en) begin
         out_valid <= emit;
         if (emit) begin
            dout     <= q_d;
            dout_ovf <= q_ovf;
         end
         if (p_valid && (p_mode == MAC_MODE_ACC)) acc <= sum;
      end
   end

endmodule
